// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
package alu_pkg;

   localparam int unsigned OPC_W = 4;

   // 4-bit opcode map inherited from the single-cycle ALU, plus the new carry/multiply ops
   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 4'h0,
      OP_XOR  = 4'h1,
      OP_BNE  = 4'h2,
      OP_ADD  = 4'h3,
      OP_LSH  = 4'h4,
      OP_RSH  = 4'h5,
      OP_SELB = 4'h6,
      OP_SELA = 4'h7,
      OP_PARI = 4'h8,
      OP_NOPB = 4'h9,
      OP_OR   = 4'hA,
      OP_SUB  = 4'hB,
      OP_ADC  = 4'hC,
      OP_SBB  = 4'hD,
      OP_MUL  = 4'hE,
      OP_ILL  = 4'hF
   } opcode_e;

   // Control states: waiting for work, iterating a multiply, holding a result
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Opcodes that produce a zero result and raise the illegal flag
   function automatic logic is_illegal(input opcode_e op);
      return (op == OP_NOP) || (op == OP_ILL);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the operand-read stage and the ALU.
interface alu_seq_if #(
   parameter int unsigned W = 8,
   parameter int unsigned A = 3
);

   logic         in_valid;
   logic         in_ready;
   logic [A:0]   alu_cmd;
   logic [W-1:0] inA;
   logic [W-1:0] inB;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] rslt;
   logic [W-1:0] rslt_hi;
   logic         sc_o;
   logic         zero;
   logic         pari;
   logic         illegal;
   logic         cflag;

   // Controller side: offers operations and consumes results
   modport master (
      output in_valid, alu_cmd, inA, inB, out_ready,
      input  in_ready, out_valid, rslt, rslt_hi, sc_o, zero, pari, illegal, cflag
   );

   // ALU side
   modport slave (
      input  in_valid, alu_cmd, inA, inB, out_ready,
      output in_ready, out_valid, rslt, rslt_hi, sc_o, zero, pari, illegal, cflag
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle for W cycles.
// product presents the value the accumulator takes at the coming edge, so it is
// final while done is high and the owner can capture it on that same edge.
module alu_mul_iter #(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int unsigned CW = $clog2(W + 1);

   logic [W-1:0]  mcand;
   logic [W-1:0]  acc_hi;
   logic [W-1:0]  acc_lo;
   logic [CW-1:0] cnt;
   logic [W:0]    sum;
   logic [2*W-1:0] acc_nxt;

   // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      acc_nxt = {sum, acc_lo[W-1:1]};
      product = acc_nxt;
      busy    = (cnt != '0);
      done    = (cnt == CW'(1));
   end

   // Operand load on start, otherwise iterate while steps remain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= a;
         acc_hi <= '0;
         acc_lo <= b;
         cnt    <= CW'(W);
      end else if (busy) begin
         {acc_hi, acc_lo} <= acc_nxt;
         cnt              <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, carry-chained add/sub,
// a carry/zero/parity flag set and an iterative W-cycle multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned A = 3
) (
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus
);

   state_e state;
   state_e state_nxt;

   logic         rdy;
   logic         load_alu;
   logic         mul_start;
   logic         load_mul;
   logic [A:0]   cmd;
   opcode_e      op;

   logic [W-1:0] res_c;
   logic         sc_c;
   logic         ill_c;
   logic [W:0]   ext;

   logic         mul_busy;
   logic         mul_done;
   logic [2*W-1:0] mul_prod;

   logic         valid_q;
   logic [W-1:0] rslt_q;
   logic [W-1:0] hi_q;
   logic         sc_q;
   logic         zero_q;
   logic         pari_q;
   logic         ill_q;
   logic         cflag_q;

   assign cmd = bus.alu_cmd;
   assign op  = opcode_e'(cmd);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state, acceptance and load strobes
   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      load_alu  = 1'b0;
      mul_start = 1'b0;
      load_mul  = 1'b0;
      case (state)
         S_IDLE: begin
            rdy = 1'b1;
         end
         S_MUL: begin
            if (mul_busy && mul_done) begin
               load_mul  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               rdy       = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // A new op can start from IDLE or replace a result being consumed this cycle
      if (rdy && bus.in_valid) begin
         if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = S_MUL;
         end else begin
            load_alu  = 1'b1;
            state_nxt = S_DONE;
         end
      end
   end

   assign bus.in_ready = rdy;

   // Single-cycle result, carry/borrow and illegal flag for the offered opcode
   always_comb begin
      res_c = '0;
      sc_c  = 1'b0;
      ill_c = 1'b0;
      ext   = '0;
      case (op)
         OP_XOR:  res_c = bus.inB ^ bus.inA;
         OP_BNE:  res_c = W'(bus.inA != '0);
         OP_ADD: begin
            ext   = {1'b0, bus.inA} + {1'b0, bus.inB};
            res_c = ext[W-1:0];
            sc_c  = ext[W];
         end
         OP_LSH:  res_c = (bus.inA >= W'(W)) ? '0 : (bus.inB << bus.inA);
         OP_RSH:  res_c = (bus.inA >= W'(W)) ? '0 : (bus.inB >> bus.inA);
         OP_SELB: res_c = bus.inB;
         OP_SELA: res_c = bus.inA;
         OP_PARI: res_c = W'(^bus.inB);
         OP_NOPB: res_c = bus.inB;
         OP_OR:   res_c = bus.inA | bus.inB;
         OP_SUB: begin
            ext   = {1'b0, bus.inA} - {1'b0, bus.inB};
            res_c = ext[W-1:0];
            sc_c  = ext[W];
         end
         OP_ADC: begin
            ext   = {1'b0, bus.inA} + {1'b0, bus.inB} + (W+1)'(cflag_q);
            res_c = ext[W-1:0];
            sc_c  = ext[W];
         end
         OP_SBB: begin
            // Borrow out of the W+1-bit difference is A < B + cflag
            ext   = {1'b0, bus.inA} - {1'b0, bus.inB} - (W+1)'(cflag_q);
            res_c = ext[W-1:0];
            sc_c  = ext[W];
         end
         OP_MUL:  res_c = '0;
         OP_NOP,
         OP_ILL:  ill_c = is_illegal(op);
         default: res_c = '0;
      endcase
   end

   alu_mul_iter #(.W(W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (bus.inA),
      .b       (bus.inB),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Result and flag registers; cflag follows sc_o on every result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         rslt_q  <= '0;
         hi_q    <= '0;
         sc_q    <= 1'b0;
         zero_q  <= 1'b0;
         pari_q  <= 1'b0;
         ill_q   <= 1'b0;
         cflag_q <= 1'b0;
      end else begin
         valid_q <= (state_nxt == S_DONE);
         if (load_alu) begin
            rslt_q  <= res_c;
            hi_q    <= '0;
            sc_q    <= sc_c;
            zero_q  <= (res_c == '0);
            pari_q  <= ^res_c;
            ill_q   <= ill_c;
            cflag_q <= sc_c;
         end else if (load_mul) begin
            rslt_q  <= mul_prod[W-1:0];
            hi_q    <= mul_prod[2*W-1:W];
            sc_q    <= (mul_prod[2*W-1:W] != '0);
            zero_q  <= (mul_prod == '0);
            pari_q  <= ^mul_prod[W-1:0];
            ill_q   <= 1'b0;
            cflag_q <= (mul_prod[2*W-1:W] != '0);
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.rslt      = rslt_q;
   assign bus.rslt_hi   = hi_q;
   assign bus.sc_o      = sc_q;
   assign bus.zero      = zero_q;
   assign bus.pari      = pari_q;
   assign bus.illegal   = ill_q;
   assign bus.cflag     = cflag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   cf_m   = 0;

   alu_seq_if #(.W(W), .A(3)) bus ();

   alu_seq #(.W(W), .A(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: expected result fields from plain integer arithmetic
   function automatic void model(input int cmd, input int a, input int b, input int cf,
                                 output int lo, output int hi, output int sc, output int ill);
      int t;
      lo = 0; hi = 0; sc = 0; ill = 0;
      case (cmd)
         1:  lo = a ^ b;
         2:  lo = (a != 0) ? 1 : 0;
         3:  begin t = a + b; sc = (t >= MOD) ? 1 : 0; lo = t % MOD; end
         4:  lo = (a >= W) ? 0 : ((b << a) % MOD);
         5:  lo = (a >= W) ? 0 : (b >> a);
         6:  lo = b;
         7:  lo = a;
         8:  lo = $countones(b) % 2;
         9:  lo = b;
         10: lo = a | b;
         11: begin sc = (a < b) ? 1 : 0; lo = (a - b + MOD) % MOD; end
         12: begin t = a + b + cf; sc = (t >= MOD) ? 1 : 0; lo = t % MOD; end
         13: begin sc = (a < b + cf) ? 1 : 0; lo = (a - b - cf + 2 * MOD) % MOD; end
         14: begin t = a * b; lo = t % MOD; hi = t / MOD; sc = (hi != 0) ? 1 : 0; end
         default: ill = 1;
      endcase
   endfunction

   // Issue one op (called #1 after a posedge), wait for its result and check it
   task automatic run_op(input int cmd, input int a, input int b, input int stall, input bit junk);
      int lo, hi, sc, ill, lat, lows, exp_lat;
      bus.in_valid = 1'b1;
      bus.alu_cmd  = 4'(cmd);
      bus.inA      = 8'(a);
      bus.inB      = 8'(b);
      check("in_ready_issue", 64'(bus.in_ready), 64'(1));
      model(cmd, a, b, cf_m, lo, hi, sc, ill);
      cf_m = sc;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = (stall == 0);
      lat  = 1;
      lows = 0;
      while (!bus.out_valid && lat < 40) begin
         if (!bus.in_ready) lows++;
         if (junk && lat < W - 1) begin
            bus.in_valid = 1'b1;
            bus.alu_cmd  = 4'($urandom);
            bus.inA      = 8'($urandom);
            bus.inB      = 8'($urandom);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      exp_lat = (cmd == 14) ? W + 1 : 1;
      check("latency",   64'(lat),  64'(exp_lat));
      check("busy_cyc",  64'(lows), 64'((cmd == 14) ? W : 0));
      check("rslt",      64'(bus.rslt),    64'(lo));
      check("rslt_hi",   64'(bus.rslt_hi), 64'(hi));
      check("sc_o",      64'(bus.sc_o),    64'(sc));
      check("zero",      64'(bus.zero),    64'((lo == 0 && hi == 0) ? 1 : 0));
      check("pari",      64'(bus.pari),    64'($countones(lo) % 2));
      check("illegal",   64'(bus.illegal), 64'(ill));
      check("cflag",     64'(bus.cflag),   64'(cf_m));
      if (stall > 0) begin
         repeat (stall) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_rslt",  64'(bus.rslt),      64'(lo));
            check("stall_sc",    64'(bus.sc_o),      64'(sc));
            check("stall_rdy",   64'(bus.in_ready),  64'(0));
         end
         bus.out_ready = 1'b1;
         #1;
         check("rdy_release", 64'(bus.in_ready), 64'(1));
      end
   endtask

   task automatic idle_cycle();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_valid", 64'(bus.out_valid), 64'(0));
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.alu_cmd   = '0;
      bus.inA       = '0;
      bus.inB       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'(0));
      check("rst_rslt",  64'(bus.rslt),      64'(0));
      check("rst_cflag", 64'(bus.cflag),     64'(0));
      check("rst_ill",   64'(bus.illegal),   64'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      check("rdy_after_rst", 64'(bus.in_ready), 64'(1));

      // ADD with carry out
      run_op(3, 'hF0, 'h20, 0, 1'b0);
      check("add_lit_rslt", 64'(bus.rslt), 64'('h10));
      check("add_lit_pari", 64'(bus.pari), 64'(1));
      idle_cycle();

      // Back-to-back carry chain
      run_op(3,  'hFF, 'h01, 0, 1'b0);
      check("chain0_zero", 64'(bus.zero), 64'(1));
      run_op(12, 'h00, 'h00, 0, 1'b0);
      check("chain1_rslt", 64'(bus.rslt), 64'('h01));

      // Multiply with junk offered while busy
      run_op(14, 'hFF, 'hFF, 0, 1'b1);
      check("mul_lit_hi", 64'(bus.rslt_hi), 64'('hFE));
      idle_cycle();

      // Subtract held under back-pressure
      run_op(11, 'h03, 'h05, 5, 1'b0);
      idle_cycle();

      // Shift out-of-range, parity, illegal clearing cflag
      run_op(4,  8, 'hFF, 0, 1'b0);
      run_op(5,  9, 'hFF, 0, 1'b0);
      run_op(3,  'hFF, 'h01, 0, 1'b0);
      run_op(15, 'h12, 'h34, 0, 1'b0);
      check("ill_cflag", 64'(bus.cflag), 64'(0));
      run_op(8,  'h00, 'h07, 0, 1'b0);
      run_op(13, 'h05, 'h05, 0, 1'b0);
      run_op(13, 'h00, 'h00, 0, 1'b0);
      run_op(0,  'h01, 'h01, 0, 1'b0);
      idle_cycle();

      // Reset during a multiply
      run_op(3, 'hF0, 'h20, 0, 1'b0);
      bus.in_valid = 1'b1;
      bus.alu_cmd  = 4'(14);
      bus.inA      = 8'h0F;
      bus.inB      = 8'h0F;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("amid_valid", 64'(bus.out_valid), 64'(0));
      check("amid_rslt",  64'(bus.rslt),      64'(0));
      check("amid_hi",    64'(bus.rslt_hi),   64'(0));
      check("amid_sc",    64'(bus.sc_o),      64'(0));
      check("amid_zero",  64'(bus.zero),      64'(0));
      check("amid_pari",  64'(bus.pari),      64'(0));
      check("amid_ill",   64'(bus.illegal),   64'(0));
      check("amid_cflag", 64'(bus.cflag),     64'(0));
      cf_m = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_valid", 64'(bus.out_valid), 64'(0));
      run_op(3, 1, 1, 0, 1'b0);
      check("post_rst_add", 64'(bus.rslt), 64'(2));

      // Randomized ops with gaps and stalls
      for (int i = 0; i < 60; i++) begin
         int c, a, b, st;
         if ($urandom_range(0, 3) == 0) idle_cycle();
         c  = int'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op(c, a, b, st, (c == 14));
      end
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
